sse_mode_select: RTL and testbench

- Mode-decision controller that sits directly downstream of the 16x16 SSE engine.
- For each enabled candidate prediction mode it issues one SSE request and waits for the engine's done.
- It adds a per-mode penalty to each returned SSE and reports the lowest-cost mode and its score.
- It drives the engine's mode-select/start and consumes its 32-bit SSE result.

---
 rtl/sse_mode_select.sv | 165 ++++++++++++++++
 tb/tb_sse_mode_select.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sse_mode_select.sv
// Mode-decision controller: issues one SSE request per enabled candidate mode,
// adds that mode's penalty and keeps the cheapest (lowest index on ties).
module sse_mode_select #(
    parameter int NUM_MODES = 4,
    parameter int MODE_W    = 2,
    parameter int PEN_W     = 16,
    parameter int SSE_W     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NUM_MODES-1:0]       mode_en,
    input  logic [PEN_W*NUM_MODES-1:0] mode_pen,
    output logic                       sse_start,
    output logic [MODE_W-1:0]          sse_mode,
    input  logic [SSE_W-1:0]           sse_in,
    input  logic                       sse_done,
    output logic                       busy,
    output logic [MODE_W-1:0]          best_mode,
    output logic [SSE_W:0]             best_score,
    output logic                       none_valid,
    output logic                       done
);

    // One extra bit so the scan index can reach NUM_MODES as its end marker.
    localparam int IDX_W = MODE_W + 1;

    typedef enum logic [5:0] {
        IDLE  = 6'b000001,
        SCAN  = 6'b000010,
        ISSUE = 6'b000100,
        WAIT  = 6'b001000,
        CMP   = 6'b010000,
        DONE  = 6'b100000
    } state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [NUM_MODES-1:0]       en_q, en_d;
    logic [PEN_W*NUM_MODES-1:0] pen_q, pen_d;
    logic [SSE_W-1:0]           sse_cap_q, sse_cap_d;
    logic                       sse_start_q, sse_start_d;
    logic [MODE_W-1:0]          sse_mode_q, sse_mode_d;
    logic                       busy_q, busy_d;
    logic [MODE_W-1:0]          best_mode_q, best_mode_d;
    logic [SSE_W:0]             best_score_q, best_score_d;
    logic                       none_valid_q, none_valid_d;
    logic                       done_q, done_d;

    logic [MODE_W-1:0]          idx_lo;
    logic [PEN_W-1:0]           cur_pen;
    logic [SSE_W:0]             score;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        en_d         = en_q;
        pen_d        = pen_q;
        sse_cap_d    = sse_cap_q;
        sse_start_d  = 1'b0;
        sse_mode_d   = sse_mode_q;
        busy_d       = busy_q;
        best_mode_d  = best_mode_q;
        best_score_d = best_score_q;
        none_valid_d = none_valid_q;
        done_d       = 1'b0;

        idx_lo  = idx_q[MODE_W-1:0];
        cur_pen = pen_q[idx_lo*PEN_W +: PEN_W];
        score   = {1'b0, sse_cap_q} + {{(SSE_W+1-PEN_W){1'b0}}, cur_pen};

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    en_d         = mode_en;
                    pen_d        = mode_pen;
                    idx_d        = '0;
                    best_score_d = '1;
                    best_mode_d  = '0;
                    none_valid_d = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = SCAN;
                end
            end
            SCAN: begin
                if (idx_q == IDX_W'(NUM_MODES)) begin
                    done_d       = 1'b1;
                    none_valid_d = (en_q == '0);
                    state_d      = DONE;
                end else if (en_q[idx_lo]) begin
                    sse_start_d = 1'b1;
                    sse_mode_d  = idx_lo;
                    state_d     = ISSUE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (sse_done) begin
                    sse_cap_d = sse_in;
                    state_d   = CMP;
                end
            end
            CMP: begin
                // Strict compare keeps the earlier (lower-index) winner on ties.
                if (score < best_score_q) begin
                    best_score_d = score;
                    best_mode_d  = idx_lo;
                end
                idx_d   = idx_q + IDX_W'(1);
                state_d = SCAN;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            en_q         <= '0;
            pen_q        <= '0;
            sse_cap_q    <= '0;
            sse_start_q  <= 1'b0;
            sse_mode_q   <= '0;
            busy_q       <= 1'b0;
            best_mode_q  <= '0;
            best_score_q <= '1;
            none_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            en_q         <= en_d;
            pen_q        <= pen_d;
            sse_cap_q    <= sse_cap_d;
            sse_start_q  <= sse_start_d;
            sse_mode_q   <= sse_mode_d;
            busy_q       <= busy_d;
            best_mode_q  <= best_mode_d;
            best_score_q <= best_score_d;
            none_valid_q <= none_valid_d;
            done_q       <= done_d;
        end
    end

    assign sse_start  = sse_start_q;
    assign sse_mode   = sse_mode_q;
    assign busy       = busy_q;
    assign best_mode  = best_mode_q;
    assign best_score = best_score_q;
    assign none_valid = none_valid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sse_mode_select.sv
// Self-checking bench for sse_mode_select: a behavioural SSE engine answers each
// request, and a per-decision cost model predicts winner, score and done cycle.
module tb_sse_mode_select;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  mode_en;
    logic [63:0] mode_pen;
    logic        sse_start;
    logic [1:0]  sse_mode;
    logic [31:0] sse_in;
    logic        sse_done;
    logic        busy;
    logic [1:0]  best_mode;
    logic [32:0] best_score;
    logic        none_valid;
    logic        done;

    localparam logic [40:0] RST_VEC = {1'b0, 2'd0, 1'b0, 2'd0, 33'h1FFFFFFFF, 1'b0, 1'b0};

    int checks   = 0;
    int failures = 0;

    logic [31:0] cur_sse [4];
    int          cur_w   [4];

    int          obs_issued[$];
    int          obs_done_cyc;
    int          obs_busy_bad;
    logic [1:0]  obs_best_mode, obs_pre_mode;
    logic [32:0] obs_best_score, obs_pre_score;
    logic        obs_none, obs_after_busy, obs_after_done, obs_after_none;

    int          exp_issued[$];
    int          exp_done_cyc;
    logic [1:0]  exp_best_mode;
    logic [32:0] exp_best_score;
    logic        exp_none;

    sse_mode_select #(.NUM_MODES(4), .MODE_W(2), .PEN_W(16), .SSE_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode_en    (mode_en),
        .mode_pen   (mode_pen),
        .sse_start  (sse_start),
        .sse_mode   (sse_mode),
        .sse_in     (sse_in),
        .sse_done   (sse_done),
        .busy       (busy),
        .best_mode  (best_mode),
        .best_score (best_score),
        .none_valid (none_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic int obs_code();
        int c = 0;
        foreach (obs_issued[i]) c = c * 10 + obs_issued[i] + 1;
        return c;
    endfunction

    function automatic int exp_code();
        int c = 0;
        foreach (exp_issued[i]) c = c * 10 + exp_issued[i] + 1;
        return c;
    endfunction

    // Cost model: min over enabled modes of sse+pen, first minimum wins.
    task automatic model(input logic [3:0] en, input logic [63:0] pen);
        longint best = 64'h1FFFFFFFF;
        longint sc;
        int bm = 0;
        int cyc = 0;
        exp_issued.delete();
        for (int k = 0; k < 4; k++) begin
            if (en[k]) begin
                exp_issued.push_back(k);
                sc = longint'(cur_sse[k]) + longint'(pen[k*16 +: 16]);
                if (sc < best) begin
                    best = sc;
                    bm   = k;
                end
                cyc += 3 + cur_w[k];
            end else begin
                cyc += 1;
            end
        end
        exp_done_cyc   = cyc + 2;
        exp_best_mode  = bm[1:0];
        exp_best_score = best[32:0];
        exp_none       = (en == 4'b0000);
    endtask

    // Runs one decision; called and left at posedge+1. Ends in the cycle after done.
    task automatic run_decision(input logic [3:0] en, input logic [63:0] pen, input bit noise);
        int pending = 0;
        int cur_mode = 0;
        int cyc = 1;
        bit seen = 0;
        obs_issued.delete();
        obs_done_cyc  = -1;
        obs_busy_bad  = 0;
        obs_pre_mode  = best_mode;
        obs_pre_score = best_score;
        mode_en  = en;
        mode_pen = pen;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!seen && cyc <= 300) begin
            if (busy !== 1'b1) obs_busy_bad++;
            sse_done = 1'b0;
            sse_in   = $urandom;
            if (pending > 0) begin
                pending--;
                if (pending == 0) begin
                    sse_done = 1'b1;
                    sse_in   = cur_sse[cur_mode];
                end
            end else if (noise && $urandom_range(3) == 0) begin
                sse_done = 1'b1;
            end
            if (sse_start === 1'b1) begin
                cur_mode = int'(sse_mode);
                obs_issued.push_back(cur_mode);
                pending = cur_w[cur_mode];
            end
            if (noise) begin
                start    = 1'($urandom_range(1));
                mode_en  = 4'($urandom);
                mode_pen = {$urandom, $urandom};
            end
            if (done === 1'b1) begin
                seen           = 1;
                obs_done_cyc   = cyc;
                obs_best_mode  = best_mode;
                obs_best_score = best_score;
                obs_none       = none_valid;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start    = 1'b0;
        sse_done = 1'b0;
        obs_after_busy = busy;
        obs_after_done = done;
        obs_after_none = none_valid;
    endtask

    task automatic test_reset();
        logic [40:0] got;
        rst = 1'b1; start = 1'b0; sse_done = 1'b0; sse_in = '0;
        mode_en = '0; mode_pen = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            got = {sse_start, sse_mode, busy, best_mode, best_score, none_valid, done};
            checks++;
            if (got !== RST_VEC) begin
                failures++;
                $display("[TB] FAIL reset_idle%0d got=%h exp=%h", i, got, RST_VEC);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_tie();
        cur_sse = '{32'd500, 32'd300, 32'd300, 32'd900};
        cur_w   = '{1, 1, 1, 1};
        run_decision(4'b1111, 64'd0, 0);
        checks++;
        if (obs_code() !== 1234) begin failures++; $display("[TB] FAIL tie_issued got=%0d exp=1234", obs_code()); end
        checks++;
        if (obs_best_mode !== 2'd1) begin failures++; $display("[TB] FAIL tie_best_mode got=%0d exp=1", obs_best_mode); end
        checks++;
        if (obs_best_score !== 33'd300) begin failures++; $display("[TB] FAIL tie_best_score got=%0d exp=300", obs_best_score); end
        checks++;
        if (obs_done_cyc !== 18) begin failures++; $display("[TB] FAIL tie_done_cycle got=%0d exp=18", obs_done_cyc); end
        checks++;
        if (obs_busy_bad !== 0 || obs_after_busy !== 1'b0 || obs_after_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tie_busy_done busy_low=%0d busy_after=%b done_after=%b exp=0,0,0",
                     obs_busy_bad, obs_after_busy, obs_after_done);
        end
    endtask

    task automatic test_penalty();
        logic [63:0] pen = {16'd10, 16'd0, 16'd400, 16'd0};
        cur_sse = '{32'd1000, 32'd700, 32'd310, 32'd200};
        for (int k = 0; k < 4; k++) cur_w[k] = $urandom_range(4, 1);
        model(4'b1111, pen);
        run_decision(4'b1111, pen, 0);
        checks++;
        if (obs_best_mode !== 2'd3) begin failures++; $display("[TB] FAIL pen_best_mode got=%0d exp=3", obs_best_mode); end
        checks++;
        if (obs_best_score !== 33'd210) begin failures++; $display("[TB] FAIL pen_best_score got=%0d exp=210", obs_best_score); end
        checks++;
        if (obs_done_cyc !== exp_done_cyc) begin
            failures++; $display("[TB] FAIL pen_done_cycle got=%0d exp=%0d", obs_done_cyc, exp_done_cyc);
        end
    endtask

    task automatic test_none();
        run_decision(4'b0000, {$urandom, $urandom}, 1);
        checks++;
        if (obs_code() !== 0) begin failures++; $display("[TB] FAIL none_issued got=%0d exp=0", obs_code()); end
        checks++;
        if (obs_done_cyc !== 6) begin failures++; $display("[TB] FAIL none_done_cycle got=%0d exp=6", obs_done_cyc); end
        checks++;
        if (obs_none !== 1'b1 || obs_best_mode !== 2'd0 || obs_best_score !== 33'h1FFFFFFFF) begin
            failures++;
            $display("[TB] FAIL none_result got=%b/%0d/%h exp=1/0/1ffffffff", obs_none, obs_best_mode, obs_best_score);
        end
        checks++;
        if (obs_after_none !== 1'b1) begin failures++; $display("[TB] FAIL none_valid_hold got=%b exp=1", obs_after_none); end
    endtask

    task automatic test_no_wrap();
        logic [63:0] pen = {16'hFFFF, 16'h1234, 16'h0000, 16'h5678};
        cur_sse = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        cur_w   = '{2, 1, 3, 1};
        run_decision(4'b1010, pen, 0);
        checks++;
        if (obs_code() !== 24) begin failures++; $display("[TB] FAIL nowrap_issued got=%0d exp=24", obs_code()); end
        checks++;
        if (obs_best_mode !== 2'd1 || obs_best_score !== 33'h0FFFFFFFF) begin
            failures++; $display("[TB] FAIL nowrap_result got=%0d/%h exp=1/0ffffffff", obs_best_mode, obs_best_score);
        end
        run_decision(4'b1000, pen, 0);
        checks++;
        if (obs_best_mode !== 2'd3 || obs_best_score !== 33'h10000FFFE) begin
            failures++; $display("[TB] FAIL nowrap_sum got=%0d/%h exp=3/10000fffe", obs_best_mode, obs_best_score);
        end
    endtask

    task automatic test_abort();
        logic [40:0] got;
        logic [63:0] pen;
        int n = 0;
        cur_w = '{5, 5, 5, 5};
        mode_en = 4'b1111; mode_pen = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (sse_start !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
        checks++;
        if (sse_start !== 1'b1) begin failures++; $display("[TB] FAIL abort_issue got=%b exp=1", sse_start); end
        @(posedge clk); #1;
        start = 1'b1; mode_en = 4'b0000;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || sse_start !== 1'b0 || sse_mode !== 2'd0) begin
            failures++; $display("[TB] FAIL abort_start_ignored got=%b/%b/%0d exp=1/0/0", busy, sse_start, sse_mode);
        end
        rst = 1'b1; sse_done = 1'b1; sse_in = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            got = {sse_start, sse_mode, busy, best_mode, best_score, none_valid, done};
            checks++;
            if (got !== RST_VEC) begin
                failures++; $display("[TB] FAIL abort_reset%0d got=%h exp=%h", i, got, RST_VEC);
            end
            @(posedge clk); #1;
            sse_done = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin cur_sse[k] = $urandom; cur_w[k] = $urandom_range(3, 1); end
        pen = {$urandom, $urandom};
        model(4'b0110, pen);
        run_decision(4'b0110, pen, 0);
        checks++;
        if (obs_best_mode !== exp_best_mode || obs_best_score !== exp_best_score || obs_done_cyc !== exp_done_cyc) begin
            failures++;
            $display("[TB] FAIL abort_recover got=%0d/%h/%0d exp=%0d/%h/%0d", obs_best_mode, obs_best_score,
                     obs_done_cyc, exp_best_mode, exp_best_score, exp_done_cyc);
        end
    endtask

    task automatic test_random();
        logic [3:0]  en;
        logic [63:0] pen;
        for (int t = 0; t < 20; t++) begin
            en = 4'($urandom);
            for (int k = 0; k < 4; k++) begin
                cur_sse[k] = (t % 2 == 0) ? 32'($urandom_range(40)) : $urandom;
                cur_w[k]   = $urandom_range(4, 1);
                pen[k*16 +: 16] = (t % 2 == 0) ? 16'($urandom_range(8)) : 16'($urandom);
            end
            model(en, pen);
            run_decision(en, pen, 1);
            checks++;
            if (obs_code() !== exp_code()) begin
                failures++; $display("[TB] FAIL rand%0d_issued got=%0d exp=%0d", t, obs_code(), exp_code());
            end
            checks++;
            if (obs_done_cyc !== exp_done_cyc) begin
                failures++; $display("[TB] FAIL rand%0d_done_cycle got=%0d exp=%0d", t, obs_done_cyc, exp_done_cyc);
            end
            checks++;
            if (obs_best_mode !== exp_best_mode || obs_best_score !== exp_best_score || obs_none !== exp_none) begin
                failures++;
                $display("[TB] FAIL rand%0d_result got=%0d/%h/%b exp=%0d/%h/%b", t, obs_best_mode, obs_best_score,
                         obs_none, exp_best_mode, exp_best_score, exp_none);
            end
            checks++;
            if (obs_busy_bad !== 0 || obs_after_busy !== 1'b0 || obs_after_done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rand%0d_busy_done got=%0d/%b/%b exp=0/0/0", t, obs_busy_bad, obs_after_busy, obs_after_done);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  en;
        logic [63:0] pen;
        logic [1:0]  prev_mode;
        logic [32:0] prev_score;
        for (int t = 0; t < 4; t++) begin
            en  = 4'($urandom) | 4'b0001;
            pen = {$urandom, $urandom};
            for (int k = 0; k < 4; k++) begin cur_sse[k] = $urandom; cur_w[k] = $urandom_range(3, 1); end
            prev_mode  = exp_best_mode;
            prev_score = exp_best_score;
            model(en, pen);
            run_decision(en, pen, 0);
            if (t > 0) begin
                checks++;
                if (obs_pre_mode !== prev_mode || obs_pre_score !== prev_score) begin
                    failures++;
                    $display("[TB] FAIL b2b%0d_hold got=%0d/%h exp=%0d/%h", t, obs_pre_mode, obs_pre_score, prev_mode, prev_score);
                end
            end
            checks++;
            if (obs_best_mode !== exp_best_mode || obs_best_score !== exp_best_score || obs_done_cyc !== exp_done_cyc) begin
                failures++;
                $display("[TB] FAIL b2b%0d_result got=%0d/%h/%0d exp=%0d/%h/%0d", t, obs_best_mode, obs_best_score,
                         obs_done_cyc, exp_best_mode, exp_best_score, exp_done_cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_penalty();
        test_none();
        test_no_wrap();
        test_abort();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
